// File: rtl/alu_issuer.sv
// Command FIFO and issue stage for the accumulator ALU, with a cycle-exact 16-bit accumulator shadow.
// Optional sticky overflow flag enabled by defining ALU_ISSUER_OVF_EN.
module alu_issuer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [7:0]       cmd_data,
  input  logic             cmd_clr,
  input  logic             issue_en,
  output logic [7:0]       alu_a,
  output logic [1:0]       alu_inst,
  output logic             alu_rst,
  output logic             issued,
  output logic [15:0]      shadow,
  output logic [CNT_W-1:0] count,
  output logic             ovf,
  output logic             dbg_state
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [10:0]        mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push, pop;
  logic [10:0]        head;
  logic [7:0]         alu_a_q, alu_a_d;
  logic [1:0]         alu_inst_q, alu_inst_d;
  logic               alu_rst_q, alu_rst_d;
  logic               issued_q, issued_d;
  logic [15:0]        shadow_q, shadow_d;

  // Handshake: a command transfers on any edge where cmd_valid && cmd_ready; cmd_ready is !full only,
  // so a same-edge pop never frees a slot for a push.
  assign cmd_ready = (count_q != CNT_W'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == S_RUN) && issue_en && (count_q != '0);
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    if (state_q == S_INIT) state_d = S_RUN;
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Entry layout {clr, op[1:0], data[7:0]}; a clr entry becomes an active-low ALU reset.
  always_comb begin
    alu_a_d    = 8'h00;
    alu_inst_d = 2'b00;
    alu_rst_d  = (state_q == S_RUN);
    issued_d   = 1'b0;
    if (pop) begin
      issued_d = 1'b1;
      if (head[10]) begin
        alu_rst_d = 1'b0;
      end else begin
        alu_inst_d = head[9:8];
        alu_a_d    = head[7:0];
      end
    end
  end

  always_comb begin
    shadow_d = 16'h0000;
    if (alu_rst_q) begin
      case (alu_inst_q)
        2'b00:   shadow_d = shadow_q + {8'h00, alu_a_q};
        2'b01:   shadow_d = shadow_q - {8'h00, alu_a_q};
        2'b10:   shadow_d = shadow_q * {8'h00, alu_a_q};
        default: shadow_d = {8'h00, shadow_q[7:0] & alu_a_q};
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_INIT;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      alu_a_q    <= 8'h00;
      alu_inst_q <= 2'b00;
      alu_rst_q  <= 1'b0;
      issued_q   <= 1'b0;
      shadow_q   <= 16'h0000;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      alu_a_q    <= alu_a_d;
      alu_inst_q <= alu_inst_d;
      alu_rst_q  <= alu_rst_d;
      issued_q   <= issued_d;
      shadow_q   <= shadow_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_clr, cmd_op, cmd_data};
  end

`ifdef ALU_ISSUER_OVF_EN
  logic ovf_q, ovf_d, wrap;

  // Wrap detection mirrors the shadow update: carry on add, borrow on sub, high product bits on mul.
  always_comb begin
    wrap = 1'b0;
    case (alu_inst_q)
      2'b00:   wrap = ({1'b0, shadow_q} + {9'h000, alu_a_q}) > 17'h0FFFF;
      2'b01:   wrap = {8'h00, alu_a_q} > shadow_q;
      2'b10:   wrap = (({8'h00, shadow_q} * {16'h0000, alu_a_q}) >> 16) != 24'd0;
      default: wrap = 1'b0;
    endcase
    ovf_d = ovf_q;
    if (!alu_rst_q)  ovf_d = 1'b0;
    else if (wrap)   ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign alu_a     = alu_a_q;
  assign alu_inst  = alu_inst_q;
  assign alu_rst   = alu_rst_q;
  assign issued    = issued_q;
  assign shadow    = shadow_q;
  assign count     = count_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_issuer.sv
// Bench for alu_issuer: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_alu_issuer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [7:0]       cmd_data;
  logic             cmd_clr;
  logic             issue_en;
  logic [7:0]       alu_a;
  logic [1:0]       alu_inst;
  logic             alu_rst;
  logic             issued;
  logic [15:0]      shadow;
  logic [CNT_W-1:0] count;
  logic             ovf;
  logic             dbg_state;

  int vectors;
  int miscompares;

  alu_issuer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_clr(cmd_clr), .issue_en(issue_en), .alu_a(alu_a), .alu_inst(alu_inst),
    .alu_rst(alu_rst), .issued(issued), .shadow(shadow), .count(count), .ovf(ovf),
    .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a command queue plus the accumulator computed with plain integer arithmetic.
  logic [10:0] fifo_m[$];
  logic [10:0] head_m;
  bit          run_m;
  logic [7:0]  exp_a;
  logic [1:0]  exp_inst;
  logic        exp_rst;
  logic        exp_issued;
  logic [15:0] exp_shadow;
  logic        exp_ovf;
  int          acc_m;
  bit          push_m, pop_m;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_m.delete();
      run_m      = 0;
      exp_a      = 8'h00;
      exp_inst   = 2'b00;
      exp_rst    = 1'b0;
      exp_issued = 1'b0;
      exp_shadow = 16'h0000;
      exp_ovf    = 1'b0;
    end else begin
      acc_m = int'(exp_shadow);
      if (!exp_rst) begin
        acc_m   = 0;
        exp_ovf = 1'b0;
      end else begin
        case (exp_inst)
          2'b00: acc_m = acc_m + int'(exp_a);
          2'b01: acc_m = acc_m - int'(exp_a);
          2'b10: acc_m = acc_m * int'(exp_a);
          default: acc_m = (acc_m % 256) & int'(exp_a);
        endcase
`ifdef ALU_ISSUER_OVF_EN
        if (acc_m < 0 || acc_m > 65535) exp_ovf = 1'b1;
`endif
      end
      exp_shadow = acc_m[15:0];
      push_m = cmd_valid && (fifo_m.size() < DEPTH);
      pop_m  = run_m && issue_en && (fifo_m.size() > 0);
      exp_a      = 8'h00;
      exp_inst   = 2'b00;
      exp_rst    = run_m;
      exp_issued = 1'b0;
      if (pop_m) begin
        head_m     = fifo_m.pop_front();
        exp_issued = 1'b1;
        if (head_m[10]) begin
          exp_rst = 1'b0;
        end else begin
          exp_inst = head_m[9:8];
          exp_a    = head_m[7:0];
        end
      end
      if (push_m) fifo_m.push_back({cmd_clr, cmd_op, cmd_data});
      run_m = 1;
    end
  end

  // Observed issue stream
  logic [9:0] obs_q[$];
  int         issued_cnt;
  always @(negedge clk) begin
    if (issued === 1'b1) begin
      obs_q.push_back({alu_inst, alu_a});
      issued_cnt++;
    end
  end

  // Driver tasks
  task automatic push_one(input logic clr, input logic [1:0] op, input logic [7:0] data);
    cmd_clr = clr; cmd_op = op; cmd_data = data; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 8'h00; cmd_clr = 1'b0; issue_en = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({alu_rst, cmd_ready, count, shadow, issued, ovf} !== {1'b0, 1'b1, 3'd0, 16'h0000, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_hold: rst=%b ready=%b count=%0d shadow=%h issued=%b ovf=%b, need 0 1 0 0000 0 0",
               alu_rst, cmd_ready, count, shadow, issued, ovf);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (alu_rst !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_init_cycle: alu_rst=%b need 0", alu_rst);
    end
    @(negedge clk);
    vectors++;
    if ({alu_rst, alu_inst, alu_a, issued} !== {1'b1, 2'b00, 8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_run_nop: rst=%b inst=%b a=%h issued=%b, need 1 00 00 0",
               alu_rst, alu_inst, alu_a, issued);
    end
  endtask

  task automatic test_back_to_back();
    issue_en = 1'b1;
    cmd_clr = 1'b0; cmd_op = 2'b00; cmd_data = 8'h05; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_data = 8'h03;
    @(negedge clk);
    vectors++;
    if ({alu_inst, alu_a, issued} !== {2'b00, 8'h05, 1'b1}) begin
      miscompares++;
      $display("FAIL b2b_add5: inst=%b a=%h issued=%b, need 00 05 1", alu_inst, alu_a, issued);
    end
    cmd_op = 2'b10; cmd_data = 8'h04;
    @(negedge clk);
    vectors++;
    if ({alu_inst, alu_a, issued, shadow} !== {2'b00, 8'h03, 1'b1, 16'h0005}) begin
      miscompares++;
      $display("FAIL b2b_add3: inst=%b a=%h issued=%b shadow=%h, need 00 03 1 0005",
               alu_inst, alu_a, issued, shadow);
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({alu_inst, alu_a, issued, shadow} !== {2'b10, 8'h04, 1'b1, 16'h0008}) begin
      miscompares++;
      $display("FAIL b2b_mul4: inst=%b a=%h issued=%b shadow=%h, need 10 04 1 0008",
               alu_inst, alu_a, issued, shadow);
    end
    @(negedge clk);
    vectors++;
    if ({shadow, issued} !== {16'h0020, 1'b0}) begin
      miscompares++;
      $display("FAIL b2b_result: shadow=%h issued=%b, need 0020 0", shadow, issued);
    end
  endtask

  task automatic test_fill();
    bit accepted;
    issue_en = 1'b0;
    obs_q.delete();
    for (int i = 0; i < 5; i++) begin
      cmd_clr = 1'b0; cmd_op = 2'b00; cmd_data = 8'(8'h11 + i); cmd_valid = 1'b1;
      if (i == 4) begin
        repeat (2) begin
          @(negedge clk);
          vectors++;
          if ({count, cmd_ready} !== {3'd4, 1'b0}) begin
            miscompares++;
            $display("FAIL fill_full_hold: count=%0d ready=%b, need 4 0", count, cmd_ready);
          end
        end
        issue_en = 1'b1;
      end
      accepted = 0;
      for (int k = 0; k < 10 && !accepted; k++) begin
        accepted = cmd_ready;
        @(negedge clk);
      end
      vectors++;
      if (!accepted) begin
        miscompares++;
        $display("FAIL fill_accept: command %0d not accepted within 10 cycles", i);
      end
      if (i < 4) begin
        vectors++;
        if (count !== 3'(i + 1)) begin
          miscompares++;
          $display("FAIL fill_count: count=%0d need %0d", count, i + 1);
        end
      end
    end
    cmd_valid = 1'b0;
    repeat (8) @(negedge clk);
    vectors++;
    if (obs_q.size() != 5) begin
      miscompares++;
      $display("FAIL fill_issue_count: issued %0d commands, need 5", obs_q.size());
    end else begin
      for (int j = 0; j < 5; j++) begin
        vectors++;
        if (obs_q[j] !== {2'b00, 8'(8'h11 + j)}) begin
          miscompares++;
          $display("FAIL fill_order: slot %0d got %h need %h", j, obs_q[j], {2'b00, 8'(8'h11 + j)});
        end
      end
    end
    vectors++;
    if ({count, shadow} !== {3'd0, 16'h007F}) begin
      miscompares++;
      $display("FAIL fill_drain: count=%0d shadow=%h, need 0 007f", count, shadow);
    end
  endtask

  task automatic test_sub_and();
    logic exp_flag;
`ifdef ALU_ISSUER_OVF_EN
    exp_flag = 1'b1;
`else
    exp_flag = 1'b0;
`endif
    issue_en = 1'b1;
    push_one(1'b1, 2'b00, 8'h00);
    repeat (3) @(negedge clk);
    push_one(1'b0, 2'b01, 8'h01);
    repeat (2) @(negedge clk);
    vectors++;
    if ({shadow, ovf} !== {16'hFFFF, exp_flag}) begin
      miscompares++;
      $display("FAIL sub_borrow: shadow=%h ovf=%b, need ffff %b", shadow, ovf, exp_flag);
    end
    push_one(1'b0, 2'b11, 8'h0F);
    repeat (2) @(negedge clk);
    vectors++;
    if ({shadow, ovf} !== {16'h000F, exp_flag}) begin
      miscompares++;
      $display("FAIL and_mask: shadow=%h ovf=%b, need 000f %b", shadow, ovf, exp_flag);
    end
  endtask

  task automatic test_clr();
    issue_en = 1'b1;
    push_one(1'b0, 2'b01, 8'h10);
    push_one(1'b0, 2'b00, 8'h21);
    repeat (2) @(negedge clk);
    vectors++;
    if ({shadow, ovf} !== {16'h0020, exp_ovf}) begin
      miscompares++;
      $display("FAIL clr_setup: shadow=%h ovf=%b, need 0020 %b", shadow, ovf, exp_ovf);
    end
    cmd_clr = 1'b1; cmd_op = 2'b10; cmd_data = 8'hAA; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_clr = 1'b0; cmd_op = 2'b00; cmd_data = 8'h07;
    @(negedge clk);
    vectors++;
    if ({alu_rst, issued, alu_inst, alu_a} !== {1'b0, 1'b1, 2'b00, 8'h00}) begin
      miscompares++;
      $display("FAIL clr_issue: rst=%b issued=%b inst=%b a=%h, need 0 1 00 00",
               alu_rst, issued, alu_inst, alu_a);
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({shadow, ovf, alu_rst, alu_inst, alu_a} !== {16'h0000, 1'b0, 1'b1, 2'b00, 8'h07}) begin
      miscompares++;
      $display("FAIL clr_shadow: shadow=%h ovf=%b rst=%b inst=%b a=%h, need 0000 0 1 00 07",
               shadow, ovf, alu_rst, alu_inst, alu_a);
    end
    @(negedge clk);
    vectors++;
    if (shadow !== 16'h0007) begin
      miscompares++;
      $display("FAIL clr_add7: shadow=%h need 0007", shadow);
    end
  endtask

  task automatic test_async_rst();
    issue_en = 1'b0;
    push_one(1'b0, 2'b00, 8'h33);
    push_one(1'b0, 2'b00, 8'h44);
    vectors++;
    if (count !== 3'd2) begin
      miscompares++;
      $display("FAIL arst_queued: count=%0d need 2", count);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({count, alu_rst, cmd_ready, shadow} !== {3'd0, 1'b0, 1'b1, 16'h0000}) begin
      miscompares++;
      $display("FAIL arst_immediate: count=%0d rst=%b ready=%b shadow=%h, need 0 0 1 0000",
               count, alu_rst, cmd_ready, shadow);
    end
    @(negedge clk);
    issued_cnt = 0;
    rst = 1'b0;
    issue_en = 1'b1;
    repeat (6) @(negedge clk);
    vectors++;
    if ({issued_cnt == 0, shadow} !== {1'b1, 16'h0000}) begin
      miscompares++;
      $display("FAIL arst_discard: issued %0d commands shadow=%h, need 0 0000", issued_cnt, shadow);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      vectors++;
      if ({alu_a, alu_inst, alu_rst, issued, shadow, ovf} !==
          {exp_a, exp_inst, exp_rst, exp_issued, exp_shadow, exp_ovf}) begin
        miscompares++;
        $display("FAIL rand_outputs cyc %0d: a=%h inst=%b rst=%b iss=%b sh=%h ovf=%b, need %h %b %b %b %h %b",
                 c, alu_a, alu_inst, alu_rst, issued, shadow, ovf,
                 exp_a, exp_inst, exp_rst, exp_issued, exp_shadow, exp_ovf);
      end
      vectors++;
      if ({count, cmd_ready} !== {3'(fifo_m.size()), fifo_m.size() < DEPTH}) begin
        miscompares++;
        $display("FAIL rand_fill cyc %0d: count=%0d ready=%b, need %0d %b",
                 c, count, cmd_ready, fifo_m.size(), fifo_m.size() < DEPTH);
      end
      if (c < 380) begin
        issue_en  = ($urandom_range(0, 3) != 0);
        cmd_valid = $urandom_range(0, 1);
      end else begin
        issue_en  = 1'b1;
        cmd_valid = 1'b0;
      end
      cmd_op   = 2'($urandom_range(0, 3));
      cmd_data = 8'($urandom_range(0, 255));
      cmd_clr  = ($urandom_range(0, 7) == 0);
      @(negedge clk);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    issued_cnt = 0;
    test_reset();
    test_back_to_back();
    test_fill();
    test_sub_and();
    test_clr();
    test_async_rst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
